// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache controller: tag/address field
// positions, line geometry and the controller state encoding.
package dcache_pkg;

    localparam int unsigned LINE_W    = 256;
    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned WORD_W    = 32;

    // Tag SRAM entry layout: {valid, dirty, tag[21:0]}
    localparam int unsigned VALID_BIT = 23;
    localparam int unsigned DIRTY_BIT = 22;
    localparam int unsigned TAG_MSB   = 21;

    // CPU byte address slices
    localparam int unsigned TAG_HI   = 31;
    localparam int unsigned TAG_LO   = 10;
    localparam int unsigned INDEX_HI = 9;
    localparam int unsigned INDEX_LO = 5;
    localparam int unsigned WORD_HI  = 4;
    localparam int unsigned WORD_LO  = 2;

    typedef logic [TAG_MSB:0]           tag_t;
    typedef logic [INDEX_HI-INDEX_LO:0] index_t;
    typedef logic [WORD_HI-WORD_LO:0]   word_sel_t;
    typedef logic [LINE_W-1:0]          line_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_ALLOCATE,
        S_REFILL
    } state_e;

    // Line-aligned memory address from a tag and an index.
    function automatic logic [31:0] line_addr(input tag_t tag, input index_t index);
        return {tag, index, 5'b0};
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Off-chip memory bus between the cache controller (master) and data memory
// (slave). Signal suffixes are from the controller's point of view.
interface dcache_ctrl_if;
    import dcache_pkg::*;

    logic [31:0] mem_addr_o;
    line_t       mem_data_o;
    logic        mem_enable_o;
    logic        mem_write_o;
    line_t       mem_data_i;
    logic        mem_ack_i;

    modport master (
        output mem_addr_o,
        output mem_data_o,
        output mem_enable_o,
        output mem_write_o,
        input  mem_data_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_data_o,
        input  mem_enable_o,
        input  mem_write_o,
        output mem_data_i,
        output mem_ack_i
    );

endinterface

// File: rtl/dcache_line_merge.sv
// Combinational word access on a cache line: selects one 32-bit word for the
// load path and produces a copy of the line with that word replaced for the
// store path.
module dcache_line_merge
    import dcache_pkg::*;
(
    input  line_t       line_i,
    input  word_sel_t   word_sel_i,
    input  logic [31:0] word_i,
    output line_t       line_o,
    output logic [31:0] word_o
);

    logic [7:0] base;

    // Word select and word insert at bit offset 32*word_sel_i
    always_comb begin
        base   = {word_sel_i, 5'b0};
        line_o = line_i;
        line_o[base +: WORD_W] = word_i;
        word_o = line_i[base +: WORD_W];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Resolves hit/miss against the tag SRAM, drives tag/data SRAM accesses,
// sequences write-back and refill over the memory bus, and clears the tag
// SRAM after reset because the SRAM itself has no reset.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_data_i,
    input  logic          p1_MemRead_i,
    input  logic          p1_MemWrite_i,
    output logic [31:0]   p1_data_o,
    output logic          p1_stall_o,

    output logic [4:0]    tag_addr_o,
    output logic [23:0]   tag_data_o,
    output logic          tag_enable_o,
    output logic          tag_write_o,
    input  logic [23:0]   tag_data_i,

    output logic [4:0]    data_addr_o,
    output line_t         data_data_o,
    output logic          data_enable_o,
    output logic          data_write_o,
    input  line_t         data_data_i,

    dcache_ctrl_if.master mem
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    line_t       line_q, line_d;

    logic [31:0] mem_addr;
    line_t       mem_data;
    logic        mem_enable;
    logic        mem_write;

    tag_t        p_tag;
    index_t      p_index;
    word_sel_t   p_word;
    logic        req;
    logic        hit;
    line_t       merged_line;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign p_tag   = p1_addr_i[TAG_HI:TAG_LO];
    assign p_index = p1_addr_i[INDEX_HI:INDEX_LO];
    assign p_word  = p1_addr_i[WORD_HI:WORD_LO];
    assign req     = p1_MemRead_i | p1_MemWrite_i;
    assign hit     = tag_data_i[VALID_BIT] && (tag_data_i[TAG_MSB:0] == p_tag);

    assign unused_addr_bits = ^p1_addr_i[1:0];

    dcache_line_merge u_merge (
        .line_i     (data_data_i),
        .word_sel_i (p_word),
        .word_i     (p1_data_i),
        .line_o     (merged_line),
        .word_o     (rd_word)
    );

    assign mem.mem_addr_o   = mem_addr;
    assign mem.mem_data_o   = mem_data;
    assign mem.mem_enable_o = mem_enable;
    assign mem.mem_write_o  = mem_write;

    // State, INIT counter and refill-line registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT_ON_RESET ? S_INIT : S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic and all SRAM/bus/CPU outputs; reset overrides last
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        p1_data_o     = '0;
        p1_stall_o    = 1'b1;
        tag_addr_o    = p_index;
        tag_data_o    = '0;
        tag_enable_o  = 1'b0;
        tag_write_o   = 1'b0;
        data_addr_o   = p_index;
        data_data_o   = '0;
        data_enable_o = 1'b0;
        data_write_o  = 1'b0;
        mem_addr      = '0;
        mem_data      = '0;
        mem_enable    = 1'b0;
        mem_write     = 1'b0;

        unique case (state_q)
            S_INIT: begin
                tag_addr_o   = cnt_q;
                tag_enable_o = 1'b1;
                tag_write_o  = 1'b1;
                if (cnt_q == 5'd31) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_IDLE: begin
                p1_stall_o = 1'b0;
                if (req) begin
                    tag_enable_o  = 1'b1;
                    data_enable_o = 1'b1;
                    if (hit) begin
                        // A simultaneous read+write is handled as a store only
                        if (p1_MemWrite_i) begin
                            data_write_o = 1'b1;
                            data_data_o  = merged_line;
                            tag_write_o  = 1'b1;
                            tag_data_o   = {1'b1, 1'b1, p_tag};
                        end else begin
                            p1_data_o = rd_word;
                        end
                    end else begin
                        p1_stall_o = 1'b1;
                        state_d    = S_MISS;
                    end
                end
            end

            S_MISS: begin
                tag_enable_o  = 1'b1;
                data_enable_o = 1'b1;
                if (tag_data_i[VALID_BIT] && tag_data_i[DIRTY_BIT]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end

            S_WRITEBACK: begin
                tag_enable_o  = 1'b1;
                data_enable_o = 1'b1;
                mem_enable    = 1'b1;
                mem_write     = 1'b1;
                mem_addr      = line_addr(tag_data_i[TAG_MSB:0], p_index);
                mem_data      = data_data_i;
                if (mem.mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                mem_enable = 1'b1;
                mem_addr   = line_addr(p_tag, p_index);
                if (mem.mem_ack_i) begin
                    line_d  = mem.mem_data_i;
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                data_enable_o = 1'b1;
                data_write_o  = 1'b1;
                data_data_o   = line_q;
                tag_enable_o  = 1'b1;
                tag_write_o   = 1'b1;
                tag_data_o    = {1'b1, 1'b0, p_tag};
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset masks the current state's outputs so an in-flight memory
        // request drops immediately rather than one cycle later.
        if (rst_i) begin
            p1_stall_o   = 1'b1;
            p1_data_o    = '0;
            mem_enable   = 1'b0;
            mem_write    = 1'b0;
            tag_write_o  = 1'b0;
            data_write_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with behavioural tag/data SRAMs and a
// directed memory responder.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
    logic [4:0]   tag_addr_o, data_addr_o;
    logic [23:0]  tag_data_o, tag_data_i;
    logic         tag_enable_o, tag_write_o, data_enable_o, data_write_o;
    logic [255:0] data_data_o, data_data_i;

    dcache_ctrl_if mem_if ();

    dcache_ctrl #(.INIT_ON_RESET(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .tag_addr_o    (tag_addr_o),
        .tag_data_o    (tag_data_o),
        .tag_enable_o  (tag_enable_o),
        .tag_write_o   (tag_write_o),
        .tag_data_i    (tag_data_i),
        .data_addr_o   (data_addr_o),
        .data_data_o   (data_data_o),
        .data_enable_o (data_enable_o),
        .data_write_o  (data_write_o),
        .data_data_i   (data_data_i),
        .mem           (mem_if)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs: combinational read, write on the rising edge
    logic [23:0]  tag_mem  [32];
    logic [255:0] data_mem [32];

    assign tag_data_i  = tag_mem[tag_addr_o];
    assign data_data_i = data_mem[data_addr_o];

    always @(posedge clk) begin
        if (tag_enable_o && tag_write_o)   tag_mem[tag_addr_o]   <= tag_data_o;
        if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    end

    typedef struct { logic [4:0] addr; logic [23:0] data; } tag_exp_t;
    typedef struct { logic [31:0] addr; logic wr; logic [255:0] line; } mem_exp_t;
    typedef struct { logic chk; logic [31:0] data; } cpu_exp_t;

    tag_exp_t tag_q [$];
    mem_exp_t mem_q [$];
    cpu_exp_t cpu_q [$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with no expected entry", name);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a tag write,
    // a new memory request, or completes a CPU request.
    tag_exp_t te;
    mem_exp_t me;
    cpu_exp_t ce;
    logic     prev_en  = 1'b0;
    logic     prev_ack = 1'b0;

    always @(negedge clk) begin
        if (rst_i) begin
            check("reset_outputs",
                  {250'd0, p1_stall_o, mem_if.mem_enable_o, mem_if.mem_write_o,
                   tag_write_o, data_write_o, |p1_data_o},
                  256'b100000);
            prev_en  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (tag_enable_o && tag_write_o) begin
                if (tag_q.size() == 0) report_unexpected("tag_write");
                else begin
                    te = tag_q.pop_front();
                    check("tag_addr", tag_addr_o, te.addr);
                    check("tag_data", tag_data_o, te.data);
                end
            end
            if (mem_if.mem_enable_o && (!prev_en || prev_ack)) begin
                if (mem_q.size() == 0) report_unexpected("mem_request");
                else begin
                    me = mem_q.pop_front();
                    check("mem_addr", mem_if.mem_addr_o, me.addr);
                    check("mem_write", mem_if.mem_write_o, me.wr);
                    if (me.wr) check("mem_wb_line", mem_if.mem_data_o, me.line);
                end
            end
            if ((p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
                if (cpu_q.size() == 0) report_unexpected("cpu_done");
                else begin
                    ce = cpu_q.pop_front();
                    if (ce.chk) check("p1_data", p1_data_o, ce.data);
                end
            end
            prev_en  = mem_if.mem_enable_o;
            prev_ack = mem_if.mem_ack_i;
        end
    end

    task automatic push_init_tags();
        for (int i = 0; i < 32; i++) tag_q.push_back('{addr: 5'(i), data: 24'h0});
    endtask

    // Waits for all INIT tag writes; stall must be high on every INIT write
    task automatic init_wait();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tag_write_o) check("init_stall", p1_stall_o, 1'b1);
            if (tag_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) report_unexpected("init_timeout");
        @(negedge clk);
        check("idle_stall_after_init", p1_stall_o, 1'b0);
        check("idle_mem_en_after_init", mem_if.mem_enable_o, 1'b0);
    endtask

    task automatic issue(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d);
        @(posedge clk);
        #1;
        p1_addr_i     = a;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_data_i     = d;
    endtask

    task automatic finish_req(output int cyc);
        bit done = 0;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (!p1_stall_o) begin
                done = 1;
                break;
            end
        end
        if (!done) report_unexpected("cpu_timeout");
        @(posedge clk);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic wait_mem(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_if.mem_enable_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) report_unexpected("mem_req_timeout");
    endtask

    task automatic mem_respond(input logic [255:0] line, input bit chk_drop);
        bit ok;
        wait_mem(ok);
        if (ok) begin
            @(posedge clk);
            #1;
            mem_if.mem_ack_i  = 1'b1;
            mem_if.mem_data_i = line;
            @(posedge clk);
            #1;
            mem_if.mem_ack_i  = 1'b0;
            if (chk_drop) begin
                @(negedge clk);
                check("mem_en_drop_after_ack", mem_if.mem_enable_o, 1'b0);
            end
        end
    endtask

    logic [255:0] line1, wb_line, line2, line3;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ok;

        line1   = {32'h10000007, 32'h10000006, 32'h10000005, 32'h10000004,
                   32'h10000003, 32'h10000002, 32'hDEADBEEF, 32'h10000000};
        wb_line = {32'h10000007, 32'h10000006, 32'h10000005, 32'h10000004,
                   32'h10000003, 32'h12345678, 32'hDEADBEEF, 32'h10000000};
        line2   = {32'h20000007, 32'h20000006, 32'h20000005, 32'h20000004,
                   32'h20000003, 32'h20000002, 32'h20000001, 32'h20000000};
        line3   = {32'h30000007, 32'h30000006, 32'h30000005, 32'h30000004,
                   32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};

        // Power-up SRAM contents are junk that would alias as valid+dirty
        for (int i = 0; i < 32; i++) begin
            tag_mem[i]  = 24'hC00000 | 24'(i);
            data_mem[i] = '0;
        end

        rst_i             = 1'b1;
        p1_addr_i         = '0;
        p1_data_i         = '0;
        p1_MemRead_i      = 1'b0;
        p1_MemWrite_i     = 1'b0;
        mem_if.mem_ack_i  = 1'b0;
        mem_if.mem_data_i = '0;

        push_init_tags();
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        init_wait();

        // Cold load: miss, allocate at 0x400, refill, then hit
        mem_q.push_back('{addr: 32'h0000_0400, wr: 1'b0, line: '0});
        tag_q.push_back('{addr: 5'd0, data: 24'h800001});
        cpu_q.push_back('{chk: 1'b1, data: 32'hDEADBEEF});
        issue(32'h0000_0404, 1'b1, 1'b0, 32'h0);
        mem_respond(line1, 1'b1);
        finish_req(cyc);

        // Store hit: zero stall, line becomes dirty
        tag_q.push_back('{addr: 5'd0, data: 24'hC00001});
        cpu_q.push_back('{chk: 1'b0, data: 32'h0});
        issue(32'h0000_0408, 1'b0, 1'b1, 32'h1234_5678);
        finish_req(cyc);
        check("store_hit_cycles", cyc, 1);

        // Conflict load: write back dirty line, then allocate tag 2
        mem_q.push_back('{addr: 32'h0000_0400, wr: 1'b1, line: wb_line});
        mem_q.push_back('{addr: 32'h0000_0800, wr: 1'b0, line: '0});
        tag_q.push_back('{addr: 5'd0, data: 24'h800002});
        cpu_q.push_back('{chk: 1'b1, data: 32'h20000002});
        issue(32'h0000_0808, 1'b1, 1'b0, 32'h0);
        mem_respond('0, 1'b0);
        mem_respond(line2, 1'b1);
        finish_req(cyc);

        // Read+write on a hit behaves as a store
        tag_q.push_back('{addr: 5'd0, data: 24'hC00002});
        cpu_q.push_back('{chk: 1'b1, data: 32'h0});
        issue(32'h0000_080C, 1'b1, 1'b1, 32'h5555_AAAA);
        finish_req(cyc);
        check("rw_hit_cycles", cyc, 1);

        cpu_q.push_back('{chk: 1'b1, data: 32'h5555_AAAA});
        issue(32'h0000_080C, 1'b1, 1'b0, 32'h0);
        finish_req(cyc);
        check("load_after_rw_cycles", cyc, 1);

        // Reset while ALLOCATE holds mem_enable; a late ack must be ignored
        mem_q.push_back('{addr: 32'h0000_1020, wr: 1'b0, line: '0});
        issue(32'h0000_1020, 1'b1, 1'b0, 32'h0);
        wait_mem(ok);
        @(posedge clk);
        #1;
        rst_i        = 1'b1;
        p1_MemRead_i = 1'b0;
        push_init_tags();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        #1;
        mem_if.mem_ack_i  = 1'b1;
        mem_if.mem_data_i = line3;
        @(posedge clk);
        #1 mem_if.mem_ack_i = 1'b0;
        init_wait();

        // Cold load into index 1 after the restarted INIT
        mem_q.push_back('{addr: 32'h0000_1020, wr: 1'b0, line: '0});
        tag_q.push_back('{addr: 5'd1, data: 24'h800004});
        cpu_q.push_back('{chk: 1'b1, data: 32'h30000000});
        issue(32'h0000_1020, 1'b1, 1'b0, 32'h0);
        mem_respond(line3, 1'b1);
        finish_req(cyc);

        repeat (3) @(negedge clk);
        check("tag_q_drained", 256'(tag_q.size()), 256'd0);
        check("mem_q_drained", 256'(mem_q.size()), 256'd0);
        check("cpu_q_drained", 256'(cpu_q.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller for the direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU memory stage (p1 side) and the 32-entry tag SRAM, the 32-line data SRAM, and off-chip data memory.
- Decides hit or miss, drives tag/data SRAM reads and writes, and sequences write-back and refill.
- Owns tag-SRAM initialisation after reset, because the SRAM itself has no reset.

Parameters:
- INIT_ON_RESET, 1, 1: sweep all 32 tag entries to 24'h0 after reset; 0: skip the sweep (simulation only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- p1_addr_i  in  32  CPU byte address; [31:10] tag, [9:5] index, [4:2] word, [1:0] ignored
- p1_data_i  in  32  CPU store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data
- p1_stall_o  out  1  request not complete this cycle
- tag_addr_o  out  5  tag SRAM index
- tag_data_o  out  24  tag write data {valid, dirty, tag[21:0]}
- tag_enable_o  out  1  tag SRAM enable
- tag_write_o  out  1  tag SRAM write
- tag_data_i  in  24  tag SRAM read data (combinational)
- data_addr_o  out  5  data SRAM index
- data_data_o  out  256  data SRAM write line
- data_enable_o  out  1  data SRAM enable
- data_write_o  out  1  data SRAM write
- data_data_i  in  256  data SRAM read line (combinational)
- mem_addr_o  out  32  memory line address, [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_enable_o  out  1  memory request, held high until ack
- mem_write_o  out  1  1 = write-back, 0 = fetch
- mem_data_i  in  256  fetched line, valid when mem_ack_i = 1
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset: one clock domain, clk_i. rst_i is synchronous and active-high.
- Outputs while rst_i = 1: p1_stall_o=1, p1_data_o=0, mem_enable_o=0, mem_write_o=0, all SRAM writes=0.
- Reset mid-operation: abandon any memory transaction, drop mem_enable_o next edge, enter INIT.
- States: INIT, IDLE, MISS, WRITEBACK, ALLOCATE, REFILL.
- INIT:
  - 5-bit counter, 0 to 31.
  - Each cycle writes tag entry[cnt] = 24'h0.
  - p1_stall_o = 1.
  - After cnt = 31, go to IDLE: 32 cycles total.
  - If INIT_ON_RESET = 0, go straight to IDLE.
- IDLE, no request: no SRAM writes, p1_stall_o = 0.
- IDLE, with request:
  - Tag and data SRAMs are enabled at p1_addr_i[9:5].
  - hit = tag_data_i[23] && (tag_data_i[21:0] == p1_addr_i[31:10]).
- Read hit: p1_data_o = data_data_i word p1_addr_i[4:2] (bits 32k+31:32k), same cycle, p1_stall_o = 0.
- Write hit, same cycle, p1_stall_o = 0:
  - data SRAM written with the line, word k replaced by p1_data_i.
  - tag written {1, 1, tag}.
- Miss: p1_stall_o = 1 combinationally; next state MISS.
- MISS (1 cycle): valid && dirty goes to WRITEBACK, else to ALLOCATE.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {old tag, index, 5'b0}; mem_data_o = data_data_i.
  - On mem_ack_i go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {p1 tag, index, 5'b0}.
  - On mem_ack_i latch mem_data_i and go to REFILL.
- REFILL (1 cycle):
  - data SRAM written with the latched line; tag written {1, 0, p1 tag}; p1_stall_o = 1.
  - Go to IDLE, where the request re-evaluates as a hit. A store marks the line dirty at that point.
- mem_enable_o deasserts the cycle after ack. An ack outside WRITEBACK or ALLOCATE is ignored.
- p1_stall_o = 1 in every state except IDLE. In IDLE it equals (request && !hit).
- Read and write both asserted: treated as a write.
- The CPU holds address and data stable while stalled; this is not checked.
- Index wrap: INIT counter stops at 31 and does not wrap.

Decomposition:
- Shared package dcache_pkg holds:
  - tag field positions: VALID_BIT = 23, DIRTY_BIT = 22, TAG_MSB = 21.
  - address slices: TAG [31:10], INDEX [9:5], WORD [4:2].
  - LINE_W = 256, NUM_LINES = 32.
  - state enum.
- One natural sub-module, dcache_line_merge: combinational word insert and select on a 256-bit line, used by the write-hit path and the read mux.

Test Plan:
- Reset release -> 32 INIT cycles with tag_write_o = 1 and addresses 0..31, data 24'h0; p1_stall_o = 1 throughout, then 0.
- Load 0x0000_0404 cold -> MISS then ALLOCATE (mem_addr_o = 0x0000_0400, mem_write_o = 0); ack with line word1 = 0xDEAD_BEEF -> REFILL writes tag 24'h800001; next cycle p1_data_o = 0xDEADBEEF, stall = 0.
- Store 0x1234_5678 to 0x0000_0408 after the previous test -> zero-stall hit; tag written 24'hC00001; line word2 updated.
- Load 0x0000_0808 (same index 0, tag 2) with the dirty line present -> WRITEBACK mem_addr_o = 0x0000_0400 with mem_data_o word2 = 0x12345678; then ALLOCATE at 0x0000_0808 & ~31.
- Assert rst_i during ALLOCATE with mem_enable_o = 1 -> mem_enable_o = 0 next cycle; INIT restarts; a late mem_ack_i is ignored.
- Read and write asserted together on a hit -> only the write effect is visible; tag dirty bit set.
